// File: rtl/vector_cmd_scheduler.sv
// rtl/vector_cmd_scheduler.sv - command FIFO, 4-entry vector register file and issue sequencer for vector_processor
module vector_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 41
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module vector_cmd_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_CYCLES = 1,
  parameter int DIV_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [1:0]   cmd_dst,
  input  logic [1:0]   cmd_srca,
  input  logic [1:0]   cmd_srcb,
  input  logic [31:0]  cmd_scalar,
  input  logic         ld_valid,
  input  logic [1:0]   ld_addr,
  input  logic [255:0] ld_data,
  input  logic [1:0]   rd_addr,
  output logic [255:0] rd_data,
  output logic [255:0] vp_vec_a,
  output logic [255:0] vp_vec_b,
  output logic [31:0]  vp_scalar,
  output logic [2:0]   vp_operation,
  input  logic [255:0] vp_result,
  output logic         busy,
  output logic         done,
  output logic         err
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;
  localparam logic [2:0] OP_DIVS = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;

  localparam int MAX_CYC = (DIV_CYCLES > ALU_CYCLES) ? DIV_CYCLES : ALU_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALU_LOAD = CNT_W'(ALU_CYCLES - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       dst_q;
  logic [255:0]     regfile [4];

  logic             fifo_full;
  logic             fifo_empty;
  logic [40:0]      head;
  logic [2:0]       head_op;
  logic [1:0]       head_dst;
  logic [1:0]       head_srca;
  logic [1:0]       head_srcb;
  logic [31:0]      head_scalar;
  logic             pop;
  logic             head_illegal;
  logic             wb_en;

  vector_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (41)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid),
    .push_data ({cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_scalar}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_op, head_dst, head_srca, head_srcb, head_scalar} = head;

  assign cmd_ready    = !fifo_full;
  assign busy         = (state == S_EXEC) || !fifo_empty;
  assign pop          = (state == S_IDLE) && !fifo_empty;
  assign head_illegal = (head_op > OP_SLT);
  assign wb_en        = (state == S_EXEC) && (cnt == '0);
  assign rd_data      = regfile[rd_addr];

  // Illegal ops are popped and retired with err, never reaching EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      dst_q        <= '0;
      vp_vec_a     <= '0;
      vp_vec_b     <= '0;
      vp_scalar    <= '0;
      vp_operation <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= wb_en || (pop && head_illegal);
      err  <= pop && head_illegal;
      case (state)
        S_IDLE: begin
          if (pop && !head_illegal) begin
            vp_vec_a     <= regfile[head_srca];
            vp_vec_b     <= regfile[head_srcb];
            vp_scalar    <= head_scalar;
            vp_operation <= head_op;
            dst_q        <= head_dst;
            cnt          <= (head_op == OP_DIVS) ? DIV_LOAD : ALU_LOAD;
            state        <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Writeback takes priority over a host load to the same register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regfile[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wb_en && (dst_q == 2'(i)))
          regfile[i] <= vp_result;
        else if (ld_valid && (ld_addr == 2'(i)))
          regfile[i] <= ld_data;
      end
    end
  end
endmodule

// File: tb/tb_vector_cmd_scheduler.sv
// tb/tb_vector_cmd_scheduler.sv - directed self-checking bench for vector_cmd_scheduler
module tb_vector_cmd_scheduler;
  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [1:0]   cmd_dst;
  logic [1:0]   cmd_srca;
  logic [1:0]   cmd_srcb;
  logic [31:0]  cmd_scalar;
  logic         ld_valid;
  logic [1:0]   ld_addr;
  logic [255:0] ld_data;
  logic [1:0]   rd_addr;
  logic [255:0] rd_data;
  logic [255:0] vp_vec_a;
  logic [255:0] vp_vec_b;
  logic [31:0]  vp_scalar;
  logic [2:0]   vp_operation;
  logic [255:0] vp_result;
  logic         busy;
  logic         done;
  logic         err;

  int n_cmp = 0;
  int n_err = 0;

  vector_cmd_scheduler #(
    .FIFO_DEPTH (4),
    .ALU_CYCLES (1),
    .DIV_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_dst      (cmd_dst),
    .cmd_srca     (cmd_srca),
    .cmd_srcb     (cmd_srcb),
    .cmd_scalar   (cmd_scalar),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .vp_vec_a     (vp_vec_a),
    .vp_vec_b     (vp_vec_b),
    .vp_scalar    (vp_scalar),
    .vp_operation (vp_operation),
    .vp_result    (vp_result),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Stand-in for the combinational Q16.16 datapath
  function automatic logic [255:0] dp_model(input logic [2:0] op, input logic [255:0] a,
                                            input logic [255:0] b, input logic [31:0] s);
    logic [255:0] r;
    logic signed [63:0] xa, xb, xs, p;
    r = '0;
    xs = 64'($signed(s));
    for (int i = 0; i < 8; i++) begin
      xa = 64'($signed(a[i*32 +: 32]));
      xb = 64'($signed(b[i*32 +: 32]));
      case (op)
        3'd0:    p = xa + xb;
        3'd1:    p = xa - xb;
        3'd2:    p = (xa * xs) >>> 16;
        3'd3:    p = (xs == 64'sd0) ? 64'sd0 : (xa <<< 16) / xs;
        3'd4:    p = (xa < xb) ? 64'sh10000 : 64'sd0;
        default: p = 64'sd0;
      endcase
      r[i*32 +: 32] = p[31:0];
    end
    return r;
  endfunction

  always_comb vp_result = dp_model(vp_operation, vp_vec_a, vp_vec_b, vp_scalar);

  function automatic logic [255:0] lanes(input logic [31:0] v);
    return {8{v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [255:0] exp);
    rd_addr = addr;
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic set_cmd(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] a,
                         input logic [1:0] b, input logic [31:0] s);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_dst    = dst;
    cmd_srca   = a;
    cmd_srcb   = b;
    cmd_scalar = s;
  endtask

  task automatic load(input logic [1:0] addr, input logic [255:0] data);
    ld_valid = 1'b1;
    ld_addr  = addr;
    ld_data  = data;
    tick();
    ld_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_srca = '0; cmd_srcb = '0; cmd_scalar = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    tick(); tick();
    chk("rst_cmd_ready", 256'(cmd_ready), 256'(1));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_vp_op", 256'(vp_operation), 256'(0));
    chk("rst_vec_a", vp_vec_a, '0);
    rd_chk("rst_r0", 2'd0, '0);
    rst = 1'b0;
    tick();

    // add: 1.5 + 2.0
    load(2'd0, lanes(32'h0001_8000));
    load(2'd1, lanes(32'h0002_0000));
    rd_chk("ld_r0", 2'd0, lanes(32'h0001_8000));
    set_cmd(3'd0, 2'd2, 2'd0, 2'd1, 32'h0);
    tick();
    cmd_valid = 1'b0;
    chk("add_busy_queued", 256'(busy), 256'(1));
    tick();
    chk("add_issue_op", 256'(vp_operation), 256'(0));
    chk("add_issue_a", vp_vec_a, lanes(32'h0001_8000));
    chk("add_issue_done", 256'(done), 256'(0));
    tick();
    chk("add_done", 256'(done), 256'(1));
    chk("add_busy_done", 256'(busy), 256'(0));
    rd_chk("add_r2", 2'd2, lanes(32'h0003_8000));
    tick();
    chk("add_done_clear", 256'(done), 256'(0));

    // divs: 6.0 / 2.0 with four settle cycles
    load(2'd0, lanes(32'h0006_0000));
    set_cmd(3'd3, 2'd3, 2'd0, 2'd0, 32'h0002_0000);
    tick();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("div_hold_op_%0d", k), 256'(vp_operation), 256'(3));
      chk($sformatf("div_hold_done_%0d", k), 256'(done), 256'(0));
    end
    tick();
    chk("div_done", 256'(done), 256'(1));
    rd_chk("div_r3", 2'd3, lanes(32'h0003_0000));

    // FIFO full behind a divs, four slt retiring in order
    set_cmd(3'd3, 2'd3, 2'd0, 2'd0, 32'h0002_0000);
    tick();
    set_cmd(3'd4, 2'd2, 2'd1, 2'd0, 32'h0);
    tick();
    chk("full_div_issue", 256'(vp_operation), 256'(3));
    set_cmd(3'd4, 2'd2, 2'd0, 2'd1, 32'h0);
    tick();
    set_cmd(3'd4, 2'd2, 2'd1, 2'd0, 32'h0);
    tick();
    chk("full_ready_3", 256'(cmd_ready), 256'(1));
    set_cmd(3'd4, 2'd2, 2'd0, 2'd1, 32'h0);
    tick();
    chk("full_ready_4", 256'(cmd_ready), 256'(0));
    set_cmd(3'd0, 2'd0, 2'd1, 2'd1, 32'h0);
    tick();
    chk("full_ready_5", 256'(cmd_ready), 256'(0));
    chk("full_div_done", 256'(done), 256'(1));
    cmd_valid = 1'b0;
    tick();
    chk("full_ready_after_pop", 256'(cmd_ready), 256'(1));
    chk("full_slt_issue", 256'(vp_operation), 256'(4));
    chk("full_done_e6", 256'(done), 256'(0));
    for (int k = 7; k <= 15; k++) begin
      tick();
      chk($sformatf("slt_done_e%0d", k), 256'(done), 256'((k <= 13 && (k % 2) == 1) ? 1 : 0));
      if (k == 7 || k == 11) rd_chk($sformatf("slt_r2_e%0d", k), 2'd2, lanes(32'h0001_0000));
      if (k == 9 || k == 13) rd_chk($sformatf("slt_r2_e%0d", k), 2'd2, '0);
    end
    chk("slt_busy_end", 256'(busy), 256'(0));

    // illegal op followed by a legal add
    set_cmd(3'd6, 2'd0, 2'd0, 2'd0, 32'h0);
    tick();
    set_cmd(3'd0, 2'd2, 2'd1, 2'd1, 32'h0);
    tick();
    cmd_valid = 1'b0;
    chk("ill_done", 256'(done), 256'(1));
    chk("ill_err", 256'(err), 256'(1));
    chk("ill_vp_op_kept", 256'(vp_operation), 256'(4));
    tick();
    chk("ill_done_clear", 256'(done), 256'(0));
    chk("ill_err_clear", 256'(err), 256'(0));
    chk("ill_next_issue", 256'(vp_operation), 256'(0));
    tick();
    chk("ill_next_done", 256'(done), 256'(1));
    chk("ill_next_err", 256'(err), 256'(0));
    rd_chk("ill_next_r2", 2'd2, lanes(32'h0004_0000));
    rd_chk("ill_r0_kept", 2'd0, lanes(32'h0006_0000));

    // load colliding with writeback, same index then different index
    set_cmd(3'd0, 2'd2, 2'd0, 2'd1, 32'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    ld_valid = 1'b1; ld_addr = 2'd2; ld_data = lanes(32'hdead_beef);
    tick();
    ld_valid = 1'b0;
    chk("col_done", 256'(done), 256'(1));
    rd_chk("col_same_r2", 2'd2, lanes(32'h0008_0000));
    set_cmd(3'd0, 2'd2, 2'd0, 2'd1, 32'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    ld_valid = 1'b1; ld_addr = 2'd1; ld_data = lanes(32'h0005_0000);
    tick();
    ld_valid = 1'b0;
    rd_chk("col_diff_r2", 2'd2, lanes(32'h0008_0000));
    rd_chk("col_diff_r1", 2'd1, lanes(32'h0005_0000));

    // reset in the middle of a divs
    set_cmd(3'd3, 2'd3, 2'd0, 2'd0, 32'h0002_0000);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("rstx_pre_op", 256'(vp_operation), 256'(3));
    rst = 1'b1;
    #1;
    chk("rstx_op", 256'(vp_operation), 256'(0));
    chk("rstx_vec_a", vp_vec_a, '0);
    chk("rstx_scalar", 256'(vp_scalar), 256'(0));
    chk("rstx_busy", 256'(busy), 256'(0));
    chk("rstx_ready", 256'(cmd_ready), 256'(1));
    chk("rstx_done", 256'(done), 256'(0));
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rstx_no_done_%0d", k), 256'(done), 256'(0));
    end
    chk("rstx_ready_after", 256'(cmd_ready), 256'(1));
    for (int r = 0; r < 4; r++) rd_chk($sformatf("rstx_r%0d", r), 2'(r), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
